// File: rtl/result_bcd_stage_if.sv
// Result-to-display handshake bundle: upstream result input plus the held
// BCD/sign/overflow outputs consumed by the 7-segment driver.
interface result_bcd_stage_if #(
    parameter int DATA_W = 19
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              neg;
    logic              ovf;
    logic [3:0]        bcd2;
    logic [3:0]        bcd1;
    logic [3:0]        bcd0;
    logic [DATA_W-1:0] disp_value;

    modport master (
        output in_valid, in_data,
        input  in_ready, busy, done, neg, ovf, bcd2, bcd1, bcd0, disp_value
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, busy, done, neg, ovf, bcd2, bcd1, bcd0, disp_value
    );
endinterface

// File: rtl/result_bcd_stage.sv
// Captures one signed inference result, saturates it to +/-MAX_DISP and
// converts the magnitude to three BCD digits with a sequential
// shift-add-3 engine. Display outputs only change when a conversion ends.
module result_bcd_stage #(
    parameter int DATA_W    = 19,
    parameter int MAX_DISP  = 999,
    parameter int CONV_BITS = 10
) (
    input  logic clk1,
    input  logic reset1,
    result_bcd_stage_if.slave bus
);

    localparam int CNT_W = $clog2(CONV_BITS + 1);
    localparam int SH_W  = 12 + CONV_BITS;
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(CONV_BITS - 1);
    localparam logic [DATA_W-1:0]    MAX_WIDE   = DATA_W'(MAX_DISP);
    localparam logic [CONV_BITS-1:0] MAX_NARROW = CONV_BITS'(MAX_DISP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ABS   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Magnitude in unsigned DATA_W arithmetic: the most negative input maps
    // to 2^(DATA_W-1) without wrapping because the result is unsigned.
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v[DATA_W-1]) begin
            r = (~v) + DATA_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the doubling shift, so pre-add 3.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [DATA_W-1:0]     data_r;
    logic [CONV_BITS-1:0]  bin_r;
    logic [11:0]           bcd_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  neg_next_r;
    logic                  ovf_next_r;
    logic [CONV_BITS-1:0]  mag_r;

    logic                  in_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  neg_r;
    logic                  ovf_r;
    logic [3:0]            bcd2_r;
    logic [3:0]            bcd1_r;
    logic [3:0]            bcd0_r;
    logic [DATA_W-1:0]     disp_r;

    logic [DATA_W-1:0]     mag_full_s;
    logic                  ovf_s;
    logic [CONV_BITS-1:0]  mag_clamp_s;
    logic [11:0]           adj_s;
    logic [SH_W-1:0]       shift_s;
    logic [DATA_W-1:0]     mag_ext_s;

    // Absolute value, saturation and one shift-add-3 iteration.
    always_comb begin
        mag_full_s  = abs_mag(data_r);
        ovf_s       = (mag_full_s > MAX_WIDE);
        if (ovf_s) begin
            mag_clamp_s = MAX_NARROW;
        end else begin
            mag_clamp_s = mag_full_s[CONV_BITS-1:0];
        end
        adj_s     = {dabble_adj(bcd_r[11:8]), dabble_adj(bcd_r[7:4]), dabble_adj(bcd_r[3:0])};
        shift_s   = {adj_s, bin_r} << 1'b1;
        mag_ext_s = {{(DATA_W-CONV_BITS){1'b0}}, mag_r};
    end

    // Next-state decode for IDLE -> ABS -> SHIFT x CONV_BITS -> DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s = ST_ABS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ABS: begin
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_IDLE);
            busy_r     <= (state_s == ST_ABS) || (state_s == ST_SHIFT);
            done_r     <= (state_s == ST_DONE);
        end
    end

    // Conversion datapath and held display outputs (updated on DONE entry).
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            data_r     <= '0;
            bin_r      <= '0;
            bcd_r      <= 12'd0;
            cnt_r      <= '0;
            neg_next_r <= 1'b0;
            ovf_next_r <= 1'b0;
            mag_r      <= '0;
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
            bcd2_r     <= 4'd0;
            bcd1_r     <= 4'd0;
            bcd0_r     <= 4'd0;
            disp_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_r <= bus.in_data;
                    end
                end
                ST_ABS: begin
                    neg_next_r <= data_r[DATA_W-1];
                    ovf_next_r <= ovf_s;
                    mag_r      <= mag_clamp_s;
                    bin_r      <= mag_clamp_s;
                    bcd_r      <= 12'd0;
                    cnt_r      <= '0;
                end
                ST_SHIFT: begin
                    bcd_r <= shift_s[SH_W-1:CONV_BITS];
                    bin_r <= shift_s[CONV_BITS-1:0];
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        bcd2_r <= shift_s[SH_W-1:SH_W-4];
                        bcd1_r <= shift_s[SH_W-5:SH_W-8];
                        bcd0_r <= shift_s[SH_W-9:SH_W-12];
                        neg_r  <= neg_next_r;
                        ovf_r  <= ovf_next_r;
                        if (neg_next_r) begin
                            disp_r <= -mag_ext_s;
                        end else begin
                            disp_r <= mag_ext_s;
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.neg        = neg_r;
    assign bus.ovf        = ovf_r;
    assign bus.bcd2       = bcd2_r;
    assign bus.bcd1       = bcd1_r;
    assign bus.bcd0       = bcd0_r;
    assign bus.disp_value = disp_r;

endmodule

// File: tb/tb_result_bcd_stage.sv
// Bench for result_bcd_stage: a cycle-level reference model derived from the
// latency and saturation rules, checked every cycle, plus literal expectations.
module tb_result_bcd_stage;

    localparam int DATA_W = 19;

    logic clk1   = 1'b0;
    logic reset1 = 1'b0;
    bit   chk_en = 1'b0;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    result_bcd_stage_if #(.DATA_W(DATA_W)) bus ();

    result_bcd_stage #(
        .DATA_W    (DATA_W),
        .MAX_DISP  (999),
        .CONV_BITS (10)
    ) dut (
        .clk1   (clk1),
        .reset1 (reset1),
        .bus    (bus)
    );

    always #5 clk1 = ~clk1;

    // Reference model: phase counter since accept (0 = idle, 12 = done cycle).
    int m_cnt  = 0;
    int m_data = 0;
    int m_neg  = 0;
    int m_ovf  = 0;
    int m_d2   = 0;
    int m_d1   = 0;
    int m_d0   = 0;
    int m_disp = 0;

    function automatic int ref_mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 999) ? 999 : a;
    endfunction

    always @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            m_cnt <= 0; m_neg <= 0; m_ovf <= 0;
            m_d2 <= 0; m_d1 <= 0; m_d0 <= 0; m_disp <= 0;
        end else if (m_cnt == 0) begin
            if (bus.in_valid === 1'b1) begin
                m_cnt  <= 1;
                m_data <= int'($signed(bus.in_data));
            end
        end else if (m_cnt == 12) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 11) begin
                m_neg  <= (m_data < 0) ? 1 : 0;
                m_ovf  <= (((m_data < 0) ? -m_data : m_data) > 999) ? 1 : 0;
                m_d2   <= ref_mag(m_data) / 100;
                m_d1   <= (ref_mag(m_data) / 10) % 10;
                m_d0   <= ref_mag(m_data) % 10;
                m_disp <= (m_data < 0) ? -ref_mag(m_data) : ref_mag(m_data);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk1) begin
        if (chk_en) begin
            check("in_ready", int'(bus.in_ready), (m_cnt == 0) ? 1 : 0);
            check("busy", int'(bus.busy), (m_cnt >= 1 && m_cnt <= 11) ? 1 : 0);
            check("done", int'(bus.done), (m_cnt == 12) ? 1 : 0);
            check("neg", int'(bus.neg), m_neg);
            check("ovf", int'(bus.ovf), m_ovf);
            check("bcd2", int'(bus.bcd2), m_d2);
            check("bcd1", int'(bus.bcd1), m_d1);
            check("bcd0", int'(bus.bcd0), m_d0);
            check("disp_value", int'($signed(bus.disp_value)), m_disp);
            if (bus.done === 1'b1) begin
                done_cnt++;
            end
        end
    end

    // Present v at a negedge and hold until the accept edge has passed.
    task automatic send(input int v);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(v);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk1);
            n++;
        end
        check("accept_seen", int'(bus.in_ready === 1'b1), 1);
        @(negedge clk1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(negedge clk1);
            cycles++;
        end
        check("done_seen", int'(bus.done === 1'b1), 1);
    endtask

    task automatic check_res(input string tag, input int d2, input int d1, input int d0,
                             input int ng, input int ov, input int dv);
        check({tag, "_bcd2"}, int'(bus.bcd2), d2);
        check({tag, "_bcd1"}, int'(bus.bcd1), d1);
        check({tag, "_bcd0"}, int'(bus.bcd0), d0);
        check({tag, "_neg"}, int'(bus.neg), ng);
        check({tag, "_ovf"}, int'(bus.ovf), ov);
        check({tag, "_disp"}, int'($signed(bus.disp_value)), dv);
    endtask

    initial begin
        int c;
        int base;
        time t1;
        time t2;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 reset1 = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk1);
        check_res("reset", 0, 0, 0, 0, 0, 0);
        check("reset_ready", int'(bus.in_ready), 1);
        reset1 = 1'b0;
        @(negedge clk1);

        // 123: done in cycle 12 after accept
        send(123);
        wait_done(c);
        check("latency_123", c, 11);
        check_res("r123", 1, 2, 3, 0, 0, 123);
        @(negedge clk1);

        send(-45);
        wait_done(c);
        check_res("rm45", 0, 4, 5, 1, 0, -45);
        @(negedge clk1);
        send(0);
        wait_done(c);
        check_res("r0", 0, 0, 0, 0, 0, 0);
        @(negedge clk1);

        // saturation, including the most negative input
        send(1500);
        wait_done(c);
        check_res("r1500", 9, 9, 9, 0, 1, 999);
        @(negedge clk1);
        send(-262144);
        wait_done(c);
        check_res("rmin", 9, 9, 9, 1, 1, -999);
        @(negedge clk1);

        // in_valid held high through the busy period
        base = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(7);
        @(negedge clk1);
        bus.in_data  = DATA_W'(888);
        wait_done(c);
        t1 = $time;
        check_res("r7", 0, 0, 7, 0, 0, 7);
        @(negedge clk1);
        wait_done(c);
        t2 = $time;
        bus.in_valid = 1'b0;
        check_res("r888", 8, 8, 8, 0, 0, 888);
        check("reaccept_gap", int'((t2 - t1) / 10), 13);
        repeat (15) @(negedge clk1);
        check("two_dones", done_cnt - base, 2);

        // reset during SHIFT of a second conversion
        send(321);
        wait_done(c);
        check_res("r321", 3, 2, 1, 0, 0, 321);
        @(negedge clk1);
        send(654);
        repeat (5) @(negedge clk1);
        #2 reset1 = 1'b1;
        #1 check_res("abort", 0, 0, 0, 0, 0, 0);
        check("abort_ready", int'(bus.in_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        @(negedge clk1);
        #2 reset1 = 1'b0;
        @(negedge clk1);
        check("post_reset_ready", int'(bus.in_ready), 1);
        base = done_cnt;
        repeat (20) @(negedge clk1);
        check("no_done_after_abort", done_cnt - base, 0);

        // sweep across both saturation boundaries
        for (int v = -1100; v <= 1100; v++) begin
            send(v);
            wait_done(c);
            check("nibble_range", int'(bus.bcd2 <= 4'd9 && bus.bcd1 <= 4'd9 && bus.bcd0 <= 4'd9), 1);
            @(negedge clk1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_bcd_stage.md
Name: result_bcd_stage

Overview:
- Sits directly upstream of the 7-segment display driver. It captures one signed inference result from the DNN engine output and holds it for the display.
- It converts the result to sign plus three BCD digits with a sequential shift-add-3 (double-dabble) engine. This removes the divide/modulo logic from the display path.
- Results are saturated to the displayable range. Outputs change only when a conversion finishes, so the display never shows a partial value.

Parameters:
- DATA_W, 19, width of the signed input result.
- MAX_DISP, 999, saturation limit for the magnitude. Must be less than 1024.
- CONV_BITS, 10, number of double-dabble iterations. 2^CONV_BITS must exceed MAX_DISP.

Ports:
- clk1  input  1  system clock.
- reset1  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  signed two's-complement result.
- in_ready  output  1  block can accept a result (high only in IDLE).
- busy  output  1  conversion in progress (ABS or SHIFT state).
- done  output  1  one-cycle pulse: new digits are valid from this cycle.
- neg  output  1  held sign of the last result (1 = negative).
- ovf  output  1  held flag: last magnitude exceeded MAX_DISP and was clamped.
- bcd2  output  4  held hundreds digit.
- bcd1  output  4  held tens digit.
- bcd0  output  4  held units digit.
- disp_value  output  DATA_W  held signed clamped value, range -MAX_DISP..+MAX_DISP, for drivers that take a binary input.

Behaviour:
- Reset (asynchronous, reset1 high):
  - State goes to IDLE; iteration counter and shift register clear.
  - neg, ovf, done, bcd2, bcd1, bcd0 and disp_value all go to 0.
  - in_ready is 1 and busy is 0 while in reset and on the first cycle after it.
- FSM states are IDLE, ABS, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: capture in_data and go to ABS. This is the accept edge, E0.
  - With in_valid = 0: stay in IDLE.
- ABS (one cycle):
  - neg_next = in_data[MSB].
  - mag = absolute value, computed in DATA_W-bit unsigned arithmetic. -2^(DATA_W-1) yields magnitude 2^(DATA_W-1) with no wrap.
  - If mag > MAX_DISP: clamp mag to MAX_DISP and set ovf_next = 1; otherwise ovf_next = 0.
  - Load the low CONV_BITS bits of the clamped mag into the binary shift register, clear the 12-bit BCD accumulator, clear the counter, and go to SHIFT.
- SHIFT (CONV_BITS cycles, one iteration per edge):
  - Every BCD nibble >= 5 gets +3.
  - Then shift {BCD, bin} left by one.
  - The counter increments. On the edge where the counter = CONV_BITS-1, go to DONE.
- DONE (one cycle):
  - On the entry edge, register the final BCD nibbles into bcd2/bcd1/bcd0.
  - On the same edge, register neg_next into neg and ovf_next into ovf.
  - On the same edge, register disp_value = neg ? -clamped_mag : clamped_mag.
  - done = 1 for this cycle only; in_ready = 0. Go to IDLE on the next edge.
- Latency:
  - E0 accept, E1 ABS to SHIFT, E2..E11 shift iterations, E11 enters DONE.
  - done is high in the cycle after E11; outputs update at E11.
  - The next accept is possible at E13 at the earliest, so throughput is one result per 13 cycles.
- Held outputs:
  - neg, ovf, bcd2, bcd1, bcd0 and disp_value change only on DONE entry or reset.
  - Between conversions they hold their last value.
- Input handling:
  - in_valid while in_ready = 0 is ignored; there is no queue.
  - The upstream side must hold in_valid until in_ready is seen.
  - in_data is sampled only on the accept edge; later changes have no effect.
- Zero: in_data = 0 gives neg = 0, digits 0,0,0, ovf = 0.
- Reset mid-operation:
  - Reset during ABS or SHIFT aborts the conversion.
  - Outputs go to reset values, not the previous result. The block re-enters IDLE.
- Invariants:
  - Every output digit is in the range 0..9.
  - {bcd2, bcd1, bcd0} always equals the absolute value of disp_value.

Test Plan:
- Accept 123 at E0 -> done high in cycle 12 after E0; bcd = 1,2,3; neg = 0; ovf = 0; disp_value = 123; in_ready low for cycles 1..12.
- Accept -45 -> bcd = 0,4,5; neg = 1; ovf = 0; disp_value = -45. Then accept 0 -> bcd = 0,0,0; neg = 0.
- Accept 1500, then -262144 -> first result: bcd = 9,9,9, ovf = 1, neg = 0, disp_value = 999. Second result: bcd = 9,9,9, ovf = 1, neg = 1, disp_value = -999.
- Accept 7, hold in_valid = 1 with in_data = 888 through the busy period -> first done shows 0,0,7. Second accept happens at E13; the next done shows 8,8,8. Exactly two done pulses.
- Complete a conversion of 321, then assert reset1 during SHIFT of 654 -> digits, neg, ovf and disp_value read 0 immediately. in_ready = 1 after reset, and no done pulse follows.
- Sweep in_data over -1100..+1100 -> every result matches the saturated decimal reference, and every nibble is at most 9.
